// File: rtl/sensor_debounce_pkg.sv
// Shared encodings and default parameters for the sensor debounce stage.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Imported by the channel and top modules.
package sensor_debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1000;
    localparam int CNT_W_DEF           = 10;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } deb_state_t;

endpackage

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: 2-FF synchroniser, persistence FSM, counter and output level.
// Latency: output follows a held raw level DEBOUNCE_CYCLES+1 edges after first capture.
// Backpressure: none; free-running, strobe is a combinational "updating this edge" flag.
module sensor_debounce_ch
    import sensor_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic CLK_clk_i,
    input  logic RST_rst_i,
    input  logic raw,
    output logic level,
    output logic strobe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             out;
    logic [CNT_W-1:0] cnt;
    deb_state_t       state;

    // High on the edge at which the candidate level has persisted long enough.
    assign strobe = (state == ST_CHECK) && (s2 != out) && (cnt == CNT_LAST);
    assign level  = out;

    always_ff @(posedge CLK_clk_i or negedge RST_rst_i) begin
        if (!RST_rst_i) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            out   <= 1'b0;
            cnt   <= '0;
            state <= ST_STABLE;
        end else begin
            s1 <= raw;
            s2 <= s1;
            case (state)
                ST_STABLE: begin
                    if (s2 != out) begin
                        state <= ST_CHECK;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_CHECK: begin
                    if (s2 == out) begin
                        // Candidate level dropped out: no partial credit is kept.
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        out   <= s2;
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sensor_debounce.sv
// Debounces the raw temperature and smoke alarm lines and flags any clean-level change.
// Latency: DEBOUNCE_CYCLES+1 edges from first capture; Cambio_o aligned with the new level.
// Backpressure: none; outputs are continuous levels plus a one-cycle change pulse.
module sensor_debounce
    import sensor_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic CLK_clk_i,
    input  logic RST_rst_i,
    input  logic Sensor_Temp_raw_i,
    input  logic Sensor_Humo_raw_i,
    output logic Sensor_Temp_o,
    output logic Sensor_Humo_o,
    output logic Cambio_o
);

    logic strobe_temp;
    logic strobe_humo;

    sensor_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_temp (
        .CLK_clk_i (CLK_clk_i),
        .RST_rst_i (RST_rst_i),
        .raw       (Sensor_Temp_raw_i),
        .level     (Sensor_Temp_o),
        .strobe    (strobe_temp)
    );

    sensor_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_humo (
        .CLK_clk_i (CLK_clk_i),
        .RST_rst_i (RST_rst_i),
        .raw       (Sensor_Humo_raw_i),
        .level     (Sensor_Humo_o),
        .strobe    (strobe_humo)
    );

    // Registered on the same edge as the channel outputs so the pulse lines up with them.
    always_ff @(posedge CLK_clk_i or negedge RST_rst_i) begin
        if (!RST_rst_i) begin
            Cambio_o <= 1'b0;
        end else begin
            Cambio_o <= strobe_temp | strobe_humo;
        end
    end

endmodule

// File: tb/tb_sensor_debounce.sv
module tb_sensor_debounce;

    localparam int DC = 4;

    logic clk;
    logic rst_n;
    logic raw_t;
    logic raw_h;
    logic out_t;
    logic out_h;
    logic cambio;

    int vectors;
    int miscompares;

    // Reference model: raw sample history and the synchronised values seen per edge.
    bit rq_t[$];
    bit rq_h[$];
    bit sq_t[$];
    bit sq_h[$];
    bit m_t;
    bit m_h;
    bit m_c;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .CLK_clk_i         (clk),
        .RST_rst_i         (rst_n),
        .Sensor_Temp_raw_i (raw_t),
        .Sensor_Humo_raw_i (raw_h),
        .Sensor_Temp_o     (out_t),
        .Sensor_Humo_o     (out_h),
        .Cambio_o          (cambio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        rq_t = {1'b0, 1'b0};
        rq_h = {1'b0, 1'b0};
        sq_t = {};
        sq_h = {};
        m_t  = 1'b0;
        m_h  = 1'b0;
        m_c  = 1'b0;
    endtask

    // A level is accepted once the last DC synchronised samples all disagree with it.
    function automatic bit persisted(input bit q[$], input bit cur);
        if (q.size() < DC) return 1'b0;
        for (int i = q.size() - DC; i < q.size(); i++)
            if (q[i] == cur) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit chg_t;
        bit chg_h;
        if (!rst_n) begin
            model_reset();
        end else begin
            sq_t.push_back(rq_t[rq_t.size() - 2]);
            sq_h.push_back(rq_h[rq_h.size() - 2]);
            rq_t.push_back(raw_t);
            rq_h.push_back(raw_h);
            if (rq_t.size() > 16) begin void'(rq_t.pop_front()); void'(rq_h.pop_front()); end
            if (sq_t.size() > 16) begin void'(sq_t.pop_front()); void'(sq_h.pop_front()); end
            chg_t = persisted(sq_t, m_t);
            chg_h = persisted(sq_h, m_h);
            if (chg_t) m_t = ~m_t;
            if (chg_h) m_h = ~m_h;
            m_c = chg_t | chg_h;
        end
    endtask

    task automatic check_exp(input string tag, input logic et, input logic eh, input logic ec);
        vectors++;
        assert (out_t === et) else begin
            miscompares++;
            $error("FAIL %s Sensor_Temp_o: got %b expected %b", tag, out_t, et);
        end
        vectors++;
        assert (out_h === eh) else begin
            miscompares++;
            $error("FAIL %s Sensor_Humo_o: got %b expected %b", tag, out_h, eh);
        end
        vectors++;
        assert (cambio === ec) else begin
            miscompares++;
            $error("FAIL %s Cambio_o: got %b expected %b", tag, cambio, ec);
        end
    endtask

    // Drive at the falling edge, advance one rising edge, compare with the model 1 unit later.
    task automatic cycle(input logic r, input logic t, input logic h);
        @(negedge clk);
        rst_n = r;
        raw_t = t;
        raw_h = h;
        @(posedge clk);
        model_edge();
        #1;
        check_exp("model", m_t, m_h, m_c);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        raw_t = 1'b0;
        raw_h = 1'b0;
        model_reset();

        // Reset held with raw lines toggling.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'(($urandom >> 3) & 1), 1'(($urandom >> 5) & 1));
            check_exp("reset_hold", 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        check_exp("post_reset_idle", 1'b0, 1'b0, 1'b0);

        // Clean rise: first capture at i=0, acceptance at i=5.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check_exp("clean_rise", (i >= 5), 1'b0, (i == 5));
        end

        // Smoke glitch of 3 cycles is rejected.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1);
            check_exp("glitch_hi", 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check_exp("glitch_lo", 1'b1, 1'b0, 1'b0);
        end

        // Return temperature to 0: fall accepted at i=5.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check_exp("clean_fall", (i < 5), 1'b0, (i == 5));
        end

        // Interrupted level: 3 high, 1 low, then held from edge j (i=0).
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check_exp("interrupt_pre", 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0);
        check_exp("interrupt_gap", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check_exp("interrupt_held", (i >= 5), 1'b0, (i == 5));
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
        check_exp("interrupt_clear", 1'b0, 1'b0, 1'b0);

        // Simultaneous rise and simultaneous fall: one Cambio_o pulse each.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b1);
            check_exp("simul_rise", (i >= 5), (i >= 5), (i == 5));
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check_exp("simul_fall", (i < 5), (i < 5), (i == 5));
        end

        // Reset in the middle of a CHECK with temperature output high.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0);
        check_exp("pre_midreset", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        check_exp("in_check", 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_exp("async_reset", 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check_exp("reset_held", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check_exp("rerise", (i >= 5), 1'b0, (i == 5));
        end

        // Randomised runs of held levels with occasional resets, checked against the model.
        for (int run = 0; run < 150; run++) begin
            logic lt;
            logic lh;
            int   len;
            lt  = 1'($urandom & 1);
            lh  = 1'(($urandom >> 7) & 1);
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 40) == 0) cycle(1'b0, lt, lh);
            for (int k = 0; k < len; k++) cycle(1'b1, lt, lh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
